// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the triggered multi-channel ADC capture block.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/capture_buf.sv
// Simple dual-port sample RAM: one full channel row per address, registered read.
module capture_buf #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or read register so the RAM maps onto block memory.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/adc_multi_capture.sv
// N-channel triggered capture: arm, trigger on threshold crossing or force, capture DEPTH rows,
// then drain sample-interleaved over valid/ready.
module adc_multi_capture
  import adc_cap_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int W       = 16,
  parameter int DEPTH   = 256,
  parameter int TRIG_CH = 0,
  parameter int CW      = 3
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            arm,
  input  logic            force_trig,
  input  logic            trig_fall,
  input  logic [W-1:0]    threshold,
  input  logic            smp_valid,
  input  logic [N_CH*W-1:0] smp_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [CW-1:0]   out_chan,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  localparam int AW  = clog2(DEPTH);
  localparam int CHW = (N_CH > 1) ? clog2(N_CH) : 1;
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(N_CH - 1);

  state_t state, state_nx;

  logic [W-1:0]      x, prev, lane;
  logic              prev_ok, trig;
  logic [AW-1:0]     wr_idx, waddr, rd_idx;
  logic [CHW-1:0]    rd_ch, p_ch;
  logic              rd_done, p_vld, p_last;
  logic              we, issue, load_out, xfer;
  logic [N_CH*W-1:0] row;

  assign x     = smp_data[TRIG_CH*W +: W];
  assign trig  = smp_valid & (force_trig | (prev_ok & (trig_fall ?
                 (prev >= threshold && x < threshold) : (prev < threshold && x >= threshold))));
  assign we    = (state == ARMED && trig) || (state == CAPTURE && smp_valid);
  assign waddr = (state == ARMED) ? '0 : wr_idx;
  assign busy  = (state != IDLE);

  // Two-deep read pipeline: RAM output (p_*) feeds the output register, so a stall
  // freezes both stages and a held ready drains one word per cycle.
  assign xfer     = out_valid & out_ready;
  assign load_out = p_vld & (~out_valid | out_ready);
  assign issue    = (state == DRAIN) & ~rd_done & (~p_vld | load_out);

  capture_buf #(.WIDTH(N_CH*W), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk  (Clk),
    .we   (we),
    .waddr(waddr),
    .wdata(smp_data),
    .re   (issue),
    .raddr(rd_idx),
    .q    (row)
  );

  always_comb begin
    lane = row[W-1:0];
    for (int k = 1; k < N_CH; k++)
      if (p_ch == CHW'(k)) lane = row[k*W +: W];
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arm) state_nx = ARMED;
      ARMED:   if (trig) state_nx = CAPTURE;
      CAPTURE: if (smp_valid && wr_idx == LAST_IDX) state_nx = DRAIN;
      DRAIN:   if (xfer && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      prev      <= '0;
      prev_ok   <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      rd_ch     <= '0;
      rd_done   <= 1'b0;
      p_vld     <= 1'b0;
      p_ch      <= '0;
      p_last    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ARMED) begin
        if (smp_valid) begin
          prev    <= x;
          prev_ok <= 1'b1;
        end
      end else begin
        prev_ok <= 1'b0;
      end

      // Trigger sample lands at row 0, so capture continues from row 1.
      if (state != CAPTURE)  wr_idx <= AW'(1);
      else if (smp_valid)    wr_idx <= wr_idx + 1'b1;

      if (state != DRAIN) begin
        rd_idx  <= '0;
        rd_ch   <= '0;
        rd_done <= 1'b0;
        p_vld   <= 1'b0;
      end else begin
        if (issue) begin
          p_ch   <= rd_ch;
          p_last <= (rd_idx == LAST_IDX) && (rd_ch == LAST_CH);
          if (rd_ch == LAST_CH) begin
            rd_ch <= '0;
            if (rd_idx == LAST_IDX) rd_done <= 1'b1;
            else                    rd_idx  <= rd_idx + 1'b1;
          end else begin
            rd_ch <= rd_ch + 1'b1;
          end
        end
        if (issue)         p_vld <= 1'b1;
        else if (load_out) p_vld <= 1'b0;

        if (load_out) begin
          out_valid <= 1'b1;
          out_data  <= lane;
          out_chan  <= CW'(p_ch);
          out_last  <= p_last;
        end else if (xfer) begin
          out_valid <= 1'b0;
        end
        if (xfer && out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_multi_capture.sv
// Randomized scoreboard bench: a sequence-level model predicts every drained word of each shot.
module tb_adc_multi_capture;

  localparam int N_CH = 3, W = 16, DEPTH = 8, CW = 3, NW = N_CH * DEPTH;

  logic              Clk = 1'b0, Rst = 1'b1;
  logic              arm = 1'b0, force_trig = 1'b0, trig_fall = 1'b0;
  logic              smp_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]      threshold = '0;
  logic [N_CH*W-1:0] smp_data = '0;
  logic              out_valid, out_last, busy, done;
  logic [W-1:0]      out_data;
  logic [CW-1:0]     out_chan;

  adc_multi_capture #(.N_CH(N_CH), .W(W), .DEPTH(DEPTH), .TRIG_CH(0), .CW(CW)) dut (
    .Clk(Clk), .Rst(Rst), .arm(arm), .force_trig(force_trig), .trig_fall(trig_fall),
    .threshold(threshold), .smp_valid(smp_valid), .smp_data(smp_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [W-1:0] d; logic [CW-1:0] c; logic l; } word_t;
  typedef struct { bit v; bit f; logic [N_CH*W-1:0] d; } stim_t;

  word_t exp_q[$];
  stim_t st[$];
  int    pre_q[$];
  int    checks = 0, errors = 0, cyc = 0, xfer_cnt = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0;
  bit    rdy_all = 1'b1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(posedge Clk) cyc++;

  always @(posedge Clk) begin
    #1;
    out_ready = rdy_all ? 1'b1 : 1'($urandom % 2);
  end

  // Monitor: pops the scoreboard on every accepted word, checks stall stability and done timing.
  bit    held = 1'b0, exp_done = 1'b0;
  word_t hw;
  always @(negedge Clk) begin
    word_t e;
    if (Rst) begin
      exp_q.delete();
      held = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", {done, busy, out_valid}, 3'b100);
        exp_done = 1'b0;
        done_cnt++;
      end else if (done) begin
        chk("spurious_done", done, 0);
      end
      if (out_valid) begin
        if (!busy) chk("valid_outside_drain", busy, 1);
        if (held) chk("stall_hold", {out_data, out_chan, out_last}, {hw.d, hw.c, hw.l});
        if (out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got %0h chan %0d with no word expected", out_data, out_chan);
          end else begin
            e = exp_q.pop_front();
            chk("data", out_data, e.d);
            chk("chan", out_chan, e.c);
            chk("last", out_last, e.l);
            if (e.l) exp_done = 1'b1;
          end
          if (xfer_cnt == 0) first_cyc = cyc;
          last_cyc = cyc;
          xfer_cnt++;
        end else begin
          held = 1'b1;
          hw.d = out_data;
          hw.c = out_chan;
          hw.l = out_last;
        end
      end
    end
  end

  // Prefix samples carry the chosen ch0 values; after them come random samples with gaps.
  task automatic build(input int force_at, input int gap_pct);
    stim_t s;
    st.delete();
    foreach (pre_q[i]) begin
      s.v = 1'b1;
      s.f = (i == force_at);
      s.d = {16'($urandom), 16'($urandom), 16'(pre_q[i])};
      st.push_back(s);
    end
    for (int i = 0; i < DEPTH + 4; i++) begin
      if ($urandom_range(99) < gap_pct) begin
        s.v = 1'b0;
        s.f = 1'($urandom % 2);
        s.d = {16'($urandom), 16'($urandom), 16'($urandom)};
        st.push_back(s);
      end
      s.v = 1'b1;
      s.f = 1'($urandom % 2);
      s.d = {16'($urandom), 16'($urandom), 16'($urandom)};
      st.push_back(s);
    end
  endtask

  // Find the trigger in the valid-sample sequence, then the next DEPTH valid samples form the shot.
  task automatic model(input logic [W-1:0] thr, input bit fall, output int trig_i);
    logic [W-1:0] prev, x;
    bit    pok;
    int    n;
    word_t w;
    pok = 1'b0; n = 0; trig_i = -1; prev = '0;
    for (int i = 0; i < st.size(); i++) begin
      if (st[i].v) begin
        x = st[i].d[W-1:0];
        if (trig_i < 0) begin
          if (st[i].f || (pok && (fall ? (prev >= thr && x < thr) : (prev < thr && x >= thr))))
            trig_i = i;
          else begin
            prev = x;
            pok = 1'b1;
          end
        end
        if (trig_i >= 0 && n < DEPTH) begin
          for (int c = 0; c < N_CH; c++) begin
            w.d = st[i].d[c*W +: W];
            w.c = CW'(c);
            w.l = (n == DEPTH - 1) && (c == N_CH - 1);
            exp_q.push_back(w);
          end
          n++;
        end
      end
    end
    if (n < DEPTH) begin
      $display("FAIL stimulus: shot has only %0d of %0d samples after trigger", n, DEPTH);
      $fatal(1);
    end
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Rst = 1'b1;
    arm = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    arm = 1'b0;
    smp_valid = 1'b0;
    force_trig = 1'b0;
    @(negedge Clk);
    chk("reset_outputs", {out_valid, out_data, out_chan, out_last, busy, done}, 0);
  endtask

  // abort: 0 none, 1 reset mid-capture, 2 reset mid-drain
  task automatic run(input logic [W-1:0] thr, input bit fall, input bit rdy, input int abort);
    int ti, d0, n, i;
    bit timeout;
    model(thr, fall, ti);
    threshold = thr;
    trig_fall = fall;
    rdy_all = rdy;
    xfer_cnt = 0;
    d0 = done_cnt;
    @(posedge Clk); #1;
    arm = 1'b1;
    smp_valid = 1'b0;
    i = 0;
    while (i < st.size() && !(abort == 1 && i == ti + 3)) begin
      @(posedge Clk); #1;
      arm = 1'($urandom % 6 == 0);
      smp_valid = st[i].v;
      force_trig = st[i].f;
      smp_data = st[i].d;
      i++;
    end
    if (abort == 1) begin
      do_reset();
      return;
    end
    @(posedge Clk); #1;
    arm = 1'b0;
    smp_valid = 1'b0;
    force_trig = 1'b0;
    n = 0;
    timeout = 1'b0;
    if (abort == 2) begin
      while (xfer_cnt < 5 && n < 400) begin @(posedge Clk); n++; end
      if (n >= 400) timeout = 1'b1;
      else do_reset();
    end else begin
      while (done_cnt == d0 && n < 400) begin @(posedge Clk); n++; end
      if (n >= 400) timeout = 1'b1;
      @(negedge Clk);
      chk("word_count", xfer_cnt, NW);
      chk("queue_empty", exp_q.size(), 0);
      chk("busy_end", busy, 0);
      if (rdy) chk("throughput", last_cyc - first_cyc, NW - 1);
    end
    if (timeout) begin
      checks++;
      errors++;
      $display("FAIL timeout: shot did not complete within %0d cycles", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("reset_state", {out_valid, out_data, out_chan, out_last, busy, done}, 0);

    pre_q = '{'h7000, 'h7F00, 'h8100, 'h8200};
    build(-1, 25); run(16'h8000, 1'b0, 1'b1, 0);
    pre_q = '{'h9000, 'h7000, 'h8800};
    build(-1, 25); run(16'h8000, 1'b0, 1'b0, 0);
    pre_q = '{'h9000, 'h7000};
    build(-1, 25); run(16'h8000, 1'b1, 1'b1, 0);
    pre_q = '{'h1000, 'h1000, 'h1000, 'h1000};
    build(2, 25); run(16'h8000, 1'b0, 1'b0, 0);
    pre_q = '{$urandom % 65536, $urandom % 65536, $urandom % 65536, $urandom % 65536, $urandom % 65536};
    build(4, 25); run(16'h0000, 1'b0, 1'b0, 0);

    pre_q = '{'h7000, 'h7F00, 'h8100};
    build(-1, 25); run(16'h8000, 1'b0, 1'b1, 1);
    build(-1, 25); run(16'h8000, 1'b0, 1'b0, 2);
    build(-1, 40); run(16'h8000, 1'b0, 1'b1, 0);

    for (int k = 0; k < 6; k++) begin
      pre_q.delete();
      for (int j = 0; j < 6; j++) pre_q.push_back($urandom % 65536);
      build(5, 30);
      run(16'($urandom), 1'($urandom % 2), 1'($urandom % 2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
